// File: rtl/perm_sched.sv
// perm_sched: burst sequencer that pushes N-lane beats through a combinational bitonic
// lane permutation network into a 2-entry output FIFO. Optional macro: PERM_EXT_TAG_EN.
module perm_sched #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int LOG2N = $clog2(N),
  parameter int LW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LOG2N-1:0]   cfg_stage,
  input  logic               cfg_inv,
  input  logic [LW-1:0]      cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_bus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*W-1:0]     out_bus,
  output logic               busy,
  output logic               done,
`ifdef PERM_EXT_TAG_EN
  input  logic               cfg_ext,
  input  logic [N*LOG2N-1:0] ext_dest_bus,
  output logic               err,
`endif
  output logic [1:0]         dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid && ready; valid never waits on
  // ready, and once raised valid and its data stay put until the transfer happens.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state;
  logic [LOG2N-1:0]   s_r;
  logic               inv_r;
  logic [LW-1:0]      rem;

  logic [N*W-1:0]     fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         fifo_cnt;
  logic [1:0]         cnt_nxt;
  logic               push;
  logic               pop;

  logic [LOG2N-1:0]   tag [N];
  logic [LOG2N-1:0]   key [N];
  logic [W-1:0]       dat [N];
  logic [LOG2N-1:0]   key_t;
  logic [W-1:0]       dat_t;
  logic [2*LOG2N-1:0] dbl;
  logic [N*W-1:0]     perm_bus;

`ifdef PERM_EXT_TAG_EN
  logic               ext_r;
  logic               dup;
`endif

  assign push      = in_valid && in_ready;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign cnt_nxt   = fifo_cnt + {1'b0, push} - {1'b0, pop};
  assign out_bus   = fifo_mem[rd_ptr];
  assign dbg_state = state;

  // Destination tags: rotate the lane index within LOG2N bits via a doubled copy.
  always_comb begin
    dbl = '0;
    tag = '{default: '0};
    for (int i = 0; i < N; i++) begin
      dbl = {LOG2N'(i), LOG2N'(i)};
      if (inv_r) begin
        dbl    = dbl >> s_r;
        tag[i] = dbl[LOG2N-1:0];
      end else begin
        dbl    = dbl << s_r;
        tag[i] = dbl[2*LOG2N-1:LOG2N];
      end
`ifdef PERM_EXT_TAG_EN
      if (ext_r) tag[i] = ext_dest_bus[i*LOG2N +: LOG2N];
`endif
    end
  end

`ifdef PERM_EXT_TAG_EN
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (tag[i] == tag[j]) dup = 1'b1;
      end
    end
  end
`endif

  // Bitonic network sorting (tag, lane) pairs ascending by tag; sorted slot p is output lane p.
  always_comb begin
    key_t    = '0;
    dat_t    = '0;
    perm_bus = '0;
    for (int i = 0; i < N; i++) begin
      key[i] = tag[i];
      dat[i] = in_bus[i*W +: W];
    end
    for (int k = 2; k <= N; k = k * 2) begin
      for (int j = k / 2; j > 0; j = j / 2) begin
        for (int i = 0; i < N; i++) begin
          if ((i ^ j) > i) begin
            if (((i & k) == 0) ? (key[i] > key[i ^ j]) : (key[i] < key[i ^ j])) begin
              key_t      = key[i];
              dat_t      = dat[i];
              key[i]     = key[i ^ j];
              dat[i]     = dat[i ^ j];
              key[i ^ j] = key_t;
              dat[i ^ j] = dat_t;
            end
          end
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      perm_bus[p*W +: W] = dat[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_r      <= '0;
      inv_r    <= 1'b0;
      rem      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PERM_EXT_TAG_EN
      ext_r    <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PERM_EXT_TAG_EN
      if (push && ext_r && dup) err <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            s_r   <= cfg_stage;
            inv_r <= cfg_inv;
            rem   <= cfg_len;
`ifdef PERM_EXT_TAG_EN
            ext_r <= cfg_ext;
`endif
            if (cfg_len != '0) begin
              state    <= RUN;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // in_ready is registered from the next FIFO count, so it never sees out_ready combinationally.
          in_ready <= (cnt_nxt < 2'd2);
          if (push) begin
            rem <= rem - 1'b1;
            if (rem == LW'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          in_ready <= 1'b0;
          if (cnt_nxt == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= perm_bus;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_perm_sched.sv
// tb_perm_sched: directed bench for perm_sched (N=8, W=8) with a queue-based output scoreboard.
module tb_perm_sched;
  localparam int N     = 8;
  localparam int W     = 8;
  localparam int LOG2N = 3;
  localparam int LW    = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LOG2N-1:0]   cfg_stage = '0;
  logic               cfg_inv = 1'b0;
  logic [LW-1:0]      cfg_len = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N*W-1:0]     in_bus = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [N*W-1:0]     out_bus;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;
`ifdef PERM_EXT_TAG_EN
  logic               cfg_ext = 1'b0;
  logic [N*LOG2N-1:0] ext_dest_bus = '0;
  logic               err;
`endif

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int cyc = 0;
  logic [N*W-1:0] exp_q[$];
  logic [N*W-1:0] mon_exp;

  // Hand-derived source lane for each output lane.
  int src_f1[8]  = '{0, 4, 1, 5, 2, 6, 3, 7};
  int src_i1[8]  = '{0, 2, 4, 6, 1, 3, 5, 7};
  int src_id[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
  int src_rev[8] = '{7, 6, 5, 4, 3, 2, 1, 0};

  perm_sched #(.N(N), .W(W), .LOG2N(LOG2N), .LW(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_stage    (cfg_stage),
    .cfg_inv      (cfg_inv),
    .cfg_len      (cfg_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bus       (in_bus),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bus      (out_bus),
    .busy         (busy),
    .done         (done),
`ifdef PERM_EXT_TAG_EN
    .cfg_ext      (cfg_ext),
    .ext_dest_bus (ext_dest_bus),
    .err          (err),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack(input int base);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(base + i);
    return r;
  endfunction

  function automatic logic [N*W-1:0] permute(input int src[8], input logic [N*W-1:0] d);
    logic [N*W-1:0] r;
    r = '0;
    for (int p = 0; p < N; p++) r[p*W +: W] = d[src[p]*W +: W];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Drivers
  task automatic do_start(input int s, input bit inv, input int len);
    cfg_stage = LOG2N'(s);
    cfg_inv   = inv;
    cfg_len   = LW'(len);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_beat(input logic [N*W-1:0] d, input logic [N*W-1:0] exp);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_bus   = d;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1 waited++;
    end
    if (!in_ready) begin
      fail_timeout("in_ready_wait");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      @(posedge clk);
      acc_cnt++;
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) fail_timeout("done_wait");
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat actual=%0h expected=none", out_bus);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_bus !== mon_exp) begin
          bad++;
          $display("FAIL out_beat actual=%0h expected=%0h", out_bus, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bus", out_bus, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // s=1 forward, single beat, latency checks
    do_start(1, 1'b0, 1);
    @(negedge clk);
    check("start_busy", 64'(busy), 64'd1);
    check("start_in_ready", 64'(in_ready), 64'd1);
    send_beat(pack(0), permute(src_f1, pack(0)));
    @(negedge clk);
    check("out_valid_lat", 64'(out_valid), 64'd1);
    check("drain_in_ready", 64'(in_ready), 64'd0);
    wait_done(10, cyc);
    check("done_lat_fwd", 64'(cyc), 64'd1);
    check("done_busy_low", 64'(busy), 64'd0);

    // s=1 inverse, then identity
    do_start(1, 1'b1, 1);
    send_beat(pack(0), permute(src_i1, pack(0)));
    wait_done(10, cyc);
    check("done_lat_inv", 64'(cyc), 64'd2);
    do_start(0, 1'b0, 1);
    send_beat(pack(0), permute(src_id, pack(0)));
    wait_done(10, cyc);
    check("done_lat_id", 64'(cyc), 64'd2);

    // len=4 with downstream stalled
    out_ready = 1'b0;
    acc_cnt   = 0;
    do_start(1, 1'b0, 4);
    fork
      begin
        for (int b = 0; b < 4; b++) send_beat(pack(16 * b), permute(src_f1, pack(16 * b)));
      end
      begin
        repeat (6) @(negedge clk);
        check("stall_accepted", 64'(acc_cnt), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_bus", out_bus, permute(src_f1, pack(0)));
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(20, cyc);
        check("stall_drain_cycles", 64'(cyc), 64'd5);
      end
    join
    check("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    // len=0
    do_start(2, 1'b0, 0);
    @(negedge clk);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("len0_done_pulse", 64'(done), 64'd0);
    check("len0_state", 64'(dbg_state), 64'd0);

    // start during RUN is ignored
    do_start(1, 1'b0, 2);
    send_beat(pack(64), permute(src_f1, pack(64)));
    do_start(0, 1'b1, 5);
    send_beat(pack(80), permute(src_f1, pack(80)));
    wait_done(10, cyc);
    check("ignore_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("ignore_start_idle", 64'(dbg_state), 64'd0);

    // reset mid-burst with the FIFO full
    out_ready = 1'b0;
    do_start(1, 1'b0, 4);
    in_valid = 1'b1;
    in_bus   = pack(32);
    repeat (4) @(posedge clk);
    #1;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_bus", out_bus, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // fresh burst after reset: s=2 inverse equals s=1 forward over 3 bits
    do_start(2, 1'b1, 2);
    send_beat(pack(96), permute(src_f1, pack(96)));
    send_beat(pack(112), permute(src_f1, pack(112)));
    wait_done(10, cyc);
    check("fresh_busy", 64'(busy), 64'd0);

`ifdef PERM_EXT_TAG_EN
    for (int i = 0; i < N; i++) ext_dest_bus[i*LOG2N +: LOG2N] = LOG2N'(N - 1 - i);
    cfg_ext = 1'b1;
    do_start(0, 1'b0, 1);
    cfg_ext = 1'b0;
    send_beat(pack(0), permute(src_rev, pack(0)));
    wait_done(10, cyc);
    check("ext_rev_err", 64'(err), 64'd0);
    ext_dest_bus[0 +: LOG2N] = LOG2N'(3);
    out_ready = 1'b0;
    cfg_ext   = 1'b1;
    do_start(0, 1'b0, 1);
    cfg_ext  = 1'b0;
    in_valid = 1'b1;
    in_bus   = pack(0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("ext_dup_err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    check("ext_dup_err_sticky", 64'(err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("ext_rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
